// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined two-level carry-lookahead adder/subtractor.
// Each stage resolves GPS 4-bit groups; a single global advance gives valid/ready flow control.
module cla_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int GPS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int C = 4 * GPS;
  localparam int NSTG = WIDTH / C;
  localparam logic [WIDTH-1:0] M = WIDTH'({C{1'b1}});
  logic adv;
  logic [WIDTH-1:0] x_q [NSTG];
  logic [WIDTH-1:0] y_q [NSTG];
  logic [WIDTH-1:0] x_d [NSTG];
  logic [WIDTH-1:0] y_d [NSTG];
  logic [NSTG-1:0] c_q, c_d, v_q, v_d;
  logic ovf_q, ovf_d, zero_q, zero_d;
  // Flattened sum-of-products lookahead over group propagate/generate.
  function automatic logic [GPS:0] look(input logic [GPS-1:0] gp, input logic [GPS-1:0] gg, input logic c0);
    logic [GPS:0] r;
    logic t;
    for (int j = 0; j <= GPS; j++) begin
      r[j] = c0;
      for (int m = 0; m < j; m++) r[j] = r[j] & gp[m];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        r[j] = r[j] | t;
      end
    end
    return r;
  endfunction
  assign adv = !v_q[NSTG-1] || out_ready;
  assign in_ready = adv;
  assign out_valid = v_q[NSTG-1];
  assign sum = x_q[NSTG-1];
  assign cout = c_q[NSTG-1];
  assign ovf = ovf_q;
  assign zero = zero_q;
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH-1:0] xin, yin;
    logic ci, vi;
    logic [GPS-1:0] gp, gg;
    logic [GPS:0] cg;
    logic [C-1:0] s;
    if (k == 0) begin : g_in
      assign xin = a;
      assign yin = sub ? ~b : b;
      assign ci = sub | cin;
      assign vi = in_valid;
    end else begin : g_prev
      assign xin = x_q[k-1];
      assign yin = y_q[k-1];
      assign ci = c_q[k-1];
      assign vi = v_q[k-1];
    end
    for (genvar j = 0; j < GPS; j++) begin : g_grp
      logic [3:0] p, g, c;
      assign p = xin[k*C+4*j +: 4] ^ yin[k*C+4*j +: 4];
      assign g = xin[k*C+4*j +: 4] & yin[k*C+4*j +: 4];
      assign gp[j] = &p;
      assign gg[j] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
      assign c = {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cg[j],
                  g[1] | p[1] & g[0] | p[1] & p[0] & cg[j],
                  g[0] | p[0] & cg[j],
                  cg[j]};
      assign s[4*j +: 4] = p ^ c;
    end
    assign cg = look(gp, gg, ci);
    // Resolved sum bits overwrite the operand-A bits they consumed.
    assign x_d[k] = (xin & ~(M << (k * C))) | (WIDTH'(s) << (k * C));
    assign y_d[k] = yin;
    assign c_d[k] = cg[GPS];
    assign v_d[k] = vi;
    if (k == NSTG - 1) begin : g_last
      assign ovf_d = (xin[WIDTH-1] == yin[WIDTH-1]) && (x_d[k][WIDTH-1] != xin[WIDTH-1]);
      assign zero_d = x_d[k] == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      c_q <= '0;
      v_q <= '0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      x_q <= x_d;
      y_q <= y_d;
      c_q <= c_d;
      v_q <= v_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: scoreboard bench with directed vectors, stall/reset scenarios and random traffic.
module tb_cla_pipe_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic cin = 1'b0;
  logic sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] sum;
  logic cout, ovf, zero;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rnd = 0;
  typedef struct {
    logic [18:0] exp;
    int cyc;
    bit lat;
  } ent_t;
  ent_t sb[$];
  ent_t me;
  typedef struct {
    logic [15:0] a, b;
    logic cin, sub;
    logic [18:0] exp;
  } vec_t;
  vec_t dir[10];

  cla_pipe_addsub #(.WIDTH(16), .GPS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    int sx, sy, sr;
    logic [16:0] r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r = {1'b0, x - y};
      r[16] = x >= y;
      sr = sx - sy;
    end else begin
      r = {1'b0, x} + {1'b0, y} + {16'd0, c};
      sr = sx + sy + int'(c);
    end
    return {r[15:0], r[16], (sr > 32767) || (sr < -32768), r[15:0] == 16'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                      input logic [18:0] exp, input bit lat);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp: exp, cyc: cyc, lat: lat});
        break;
      end
      if (n > 500) begin
        total++; bad++;
        $display("FAIL accept_timeout: got in_ready=0 want 1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got %h want none", {sum, cout, ovf, zero});
      end else begin
        me = sb.pop_front();
        chk("result", {13'd0, sum, cout, ovf, zero}, {13'd0, me.exp});
        if (me.lat) chk("latency", cyc - me.cyc, 2);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd) out_ready = $urandom_range(0, 3) != 0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic rc, rs;
    dir[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1}};
    dir[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0}};
    dir[2] = '{16'h1234, 16'h0000, 1'b1, 1'b0, {16'h1235, 1'b0, 1'b0, 1'b0}};
    dir[3] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0, 1'b0}};
    dir[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0}};
    dir[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0}};
    dir[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0}};
    dir[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0}};
    dir[8] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, {16'h1000, 1'b0, 1'b0, 1'b0}};
    dir[9] = '{16'hFF00, 16'h0100, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1}};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub, dir[i].exp, 1);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, {16'h3333, 3'b000}, 0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, {16'h8000, 3'b010}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_hold", {sum, cout, ovf, zero}, {16'h3333, 3'b000});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'h0001, 16'h0001, 1'b0, 1'b1, {16'h0000, 3'b101}, 1);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'hAAAA, 16'h1111, 1'b0, 1'b0, {16'hBBBB, 3'b000}, 0);
    send(16'h2222, 16'h1111, 1'b0, 1'b1, {16'h1111, 3'b100}, 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 rnd = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 15) == 0) rb = ra;
      if ($urandom_range(0, 15) == 0) rb = ~ra;
      rc = 1'($urandom);
      rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 0);
    end
    rnd = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with group propagate/generate combined by a second lookahead level inside each stage. It generalises the single-cycle 4-bit group adder to WIDTH bits, with a configurable number of groups per pipeline stage, an add/subtract mode, and status flags. It sits between operand registers and result consumers in the datapath, behind a valid/ready handshake on both sides.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4*GPS
- GPS, 2, 4-bit groups resolved per pipeline stage; NSTG = WIDTH/(4*GPS) stages
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  0: add, 1: subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  sum == 0

## Operation
- Accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Add: {cout,sum} = a + b + cin. Subtract: {cout,sum} = a + ~b + 1; cin is ignored.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = sub ? ~b : b.
- Each group computes per-bit p = a^b_eff and g = a&b_eff, internal carries by full lookahead, and group GP/GG. Carries between groups in a stage use lookahead on GP/GG, never ripple.
- Stage k (0..NSTG-1) resolves groups k*GPS..k*GPS+GPS-1 using the carry registered by stage k-1 (stage 0 uses the effective carry-in). It registers:
  - the sum bits resolved so far;
  - the upper operand bits that are not yet resolved (skewed forward);
  - the stage carry-out;
  - a valid bit.
- The final stage registers sum, cout, ovf and zero. Flags are computed from full-width values in the last stage.
- Flow control uses one global advance: adv = !out_valid || out_ready.
  - All stage registers and valid bits load only when adv = 1.
  - in_ready = adv, combinational.
  - A stage's valid bit loads the previous stage's valid bit, or in_valid && in_ready for stage 0.
  - Bubbles propagate as valid = 0. Data in invalid stages is don't-care but deterministic.
- No combinational path from a/b to any output. The only combinational path is out_ready to in_ready.

## Timing
- Reset: all valid bits 0, so out_valid = 0 and in_ready = 1 on the first cycle after reset. sum = 0, cout = 0, ovf = 0, zero = 0 (zero is registered; it is not 1 at reset).
- Latency: an operand accepted at edge T appears with out_valid = 1 after edge T+NSTG-1, i.e. NSTG cycles. With WIDTH=16, GPS=2: NSTG = 2.
- Throughput: one result per cycle while out_ready = 1.
- Stall: out_valid && !out_ready.
  - All stages hold and in_ready = 0.
  - sum, cout, ovf and zero hold stable until accepted.
  - Upstream must hold a, b, cin, sub and in_valid.
- The cycle out_ready rises, the held result is consumed, the pipeline advances, and a new input is accepted in the same cycle.
- Reset mid-operation: all in-flight results are dropped. No result is emitted for any operand accepted before reset.
- Accept and deliver in the same cycle is legal at every occupancy level.
- Degenerate configuration NSTG = 1: a single registered stage, latency 1.

## Test plan
- WIDTH=16, GPS=2, add: a=0xFFFF, b=0x0001, cin=0 → two cycles later sum=0x0000, cout=1, ovf=0, zero=1.
- Add: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1, zero=0. Also a=0x1234, b=0x0000, cin=1 → sum=0x1235. The carry chain crossing the stage boundary (a=0x00FF, b=0x0001 → 0x0100) must be correct.
- Subtract:
  - a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
  - cin=1 with sub=1 must not change the result.
- Back-to-back stream of 8 operands with out_ready held at 1 → 8 results on 8 consecutive cycles, in order, first result at cycle 2.
- Stall: hold out_ready=0 for 3 cycles with the pipeline full → in_ready=0, and outputs are stable for all 3 cycles. Releasing out_ready drains the results in order with no loss or duplication.
- Assert rst for one cycle with 2 results in flight → out_valid=0 on the next cycle, and neither dropped result ever appears. Then 10k random operands (both modes, random valid/ready) must match a reference model for sum, cout, ovf and zero.
